bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles s_valid stays high without s_ready before abort (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning the synchronous, active-high reset.
REQ-004 SHALL have ports m0_valid (in, 1), m0_addr (in, 32), m0_wdata (in, 32) and m0_wstrb (in, 4), meaning the master-0 request; m0_wstrb=0 means read.
REQ-005 SHALL have ports m0_ready (out, 1) and m0_rdata (out, 32), meaning the master-0 response.
REQ-006 SHALL have ports m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready and m1_rdata, with the same widths, directions and meanings as master 0.
REQ-007 SHALL have ports s_valid (out, 1), s_addr (out, 32), s_wdata (out, 32) and s_wstrb (out, 4), meaning the shared slave-side request into the bus decoder.
REQ-008 SHALL have ports s_ready (in, 1) and s_rdata (in, 32), meaning the slave-side response from the bus decoder.
REQ-009 SHALL have port timeout_err, output, 1, meaning a one-cycle pulse on transaction abort.

Function
REQ-010 SHALL implement three states IDLE, REQ and RESP, plus a grant register g (0/1) and a last-served register last.
REQ-011 IDLE with neither valid high: SHALL stay in IDLE with all outputs at reset values.
REQ-012 IDLE with exactly one mX_valid high: SHALL set g=X, latch mX_addr/wdata/wstrb into s_addr/s_wdata/s_wstrb, set s_valid=1 and go to REQ.
REQ-013 IDLE with both valid high (round-robin): SHALL grant the master with index != last.
REQ-014 REQ: SHALL hold s_valid=1 with the latched s_addr/s_wdata/s_wstrb stable.
REQ-015 REQ: SHALL count cycles in a 16-bit counter that is cleared on entry to REQ.
REQ-016 REQ with s_ready=1: SHALL capture s_rdata into mg_rdata, clear s_valid, set last=g and go to RESP.
REQ-017 REQ with s_ready=0 when the counter equals TIMEOUT-1: SHALL clear s_valid, load mg_rdata=32'hFFFF_FFFF, pulse timeout_err for one cycle, set last=g and go to RESP.
REQ-018 REQ when s_ready=1 and the timeout condition occur in the same cycle: s_ready SHALL win and no timeout_err is raised.
REQ-019 RESP: SHALL assert mg_ready=1 for exactly one cycle, then go to IDLE.
REQ-020 RESP: the non-granted master's ready SHALL be 0.
REQ-021 mX_rdata SHALL hold its last value until it is next loaded.
REQ-022 Latency: SHALL assert s_valid 1 cycle after valid is sampled in IDLE, and mg_ready 1 cycle after s_ready is sampled.
REQ-023 Minimum transaction length SHALL be 3 cycles, valid-sample to ready.
REQ-024 SHALL ignore s_ready outside REQ.
REQ-025 SHALL ignore mX_valid outside IDLE; a requesting master waits with its request held.
REQ-026 SHALL never assert m0_ready and m1_ready in the same cycle.
REQ-027 SHALL never assert s_valid in IDLE or RESP.
REQ-028 Writes SHALL follow the same sequence as reads; mg_rdata for a write is the captured s_rdata, which the master disregards.
REQ-029 SHALL treat a master dropping valid during REQ as having no effect; the transaction completes.

Reset
REQ-030 On reset=1 at a rising edge, SHALL set state=IDLE, g=0, last=1 (so m0 wins the first tie) and counter=0.
REQ-031 On reset, SHALL set s_valid=0, s_addr=0, s_wdata=0, s_wstrb=0, m0_ready=0, m1_ready=0, m0_rdata=0, m1_rdata=0 and timeout_err=0.
REQ-032 Reset asserted in REQ or RESP SHALL abandon the transaction: no ready pulse, no timeout_err, and outputs at reset values the next cycle.

Verification
REQ-033 Single read: m0 read 0x0000_0100; slave returns ready 2 cycles after s_valid with data 0x1234_5678 -> s_addr=0x100, then m0_ready for one cycle with m0_rdata=0x1234_5678, m1_ready=0 throughout.
REQ-034 Tie after reset: m0 and m1 both valid in the same cycle -> m0 served first, then m1 without an idle gap beyond the RESP->IDLE cycle; repeated ties alternate m1,m0,m1.
REQ-035 Write: m1 write 0xFFFF_0040 with wdata=0xA5 and wstrb=4'b0001 -> s_wstrb=4'b0001 and s_wdata=0xA5 stable until s_ready; m1_ready pulses once.
REQ-036 Timeout: TIMEOUT=4; slave never ready -> s_valid high exactly 4 cycles, timeout_err one-cycle pulse, m0_rdata=0xFFFF_FFFF with m0_ready next cycle.
REQ-037 Reset mid-transaction: reset in the 2nd REQ cycle -> next cycle s_valid=0, no m0_ready and no timeout_err; a subsequent m1-only request is served normally.
REQ-038 Boundary: s_ready on the same cycle as the timeout count -> normal completion with s_rdata and timeout_err=0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto a single slave request port, with a
// per-transaction ready timeout that aborts and returns all-ones read data.
module bus_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic        timeout_err
);

   localparam int unsigned DW    = 32;
   localparam int unsigned SW    = 4;
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t            state_q, state_d;
   logic              g_q, g_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              s_valid_q, s_valid_d;
   logic [DW-1:0]     s_addr_q, s_addr_d;
   logic [DW-1:0]     s_wdata_q, s_wdata_d;
   logic [SW-1:0]     s_wstrb_q, s_wstrb_d;
   logic              m0_ready_q, m0_ready_d;
   logic              m1_ready_q, m1_ready_d;
   logic [DW-1:0]     m0_rdata_q, m0_rdata_d;
   logic [DW-1:0]     m1_rdata_q, m1_rdata_d;
   logic              timeout_err_q, timeout_err_d;
   logic              grant;
   logic [DW-1:0]     rsp_data;

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         g_q           <= 1'b0;
         last_q        <= 1'b1;
         cnt_q         <= '0;
         s_valid_q     <= 1'b0;
         s_addr_q      <= '0;
         s_wdata_q     <= '0;
         s_wstrb_q     <= '0;
         m0_ready_q    <= 1'b0;
         m1_ready_q    <= 1'b0;
         m0_rdata_q    <= '0;
         m1_rdata_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         g_q           <= g_d;
         last_q        <= last_d;
         cnt_q         <= cnt_d;
         s_valid_q     <= s_valid_d;
         s_addr_q      <= s_addr_d;
         s_wdata_q     <= s_wdata_d;
         s_wstrb_q     <= s_wstrb_d;
         m0_ready_q    <= m0_ready_d;
         m1_ready_q    <= m1_ready_d;
         m0_rdata_q    <= m0_rdata_d;
         m1_rdata_q    <= m1_rdata_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d       = state_q;
      g_d           = g_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      s_valid_d     = s_valid_q;
      s_addr_d      = s_addr_q;
      s_wdata_d     = s_wdata_q;
      s_wstrb_d     = s_wstrb_q;
      m0_ready_d    = 1'b0;
      m1_ready_d    = 1'b0;
      m0_rdata_d    = m0_rdata_q;
      m1_rdata_d    = m1_rdata_q;
      timeout_err_d = 1'b0;
      grant         = 1'b0;
      rsp_data      = '0;

      case (state_q)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               // On a tie the master not served last wins
               grant     = (m0_valid && m1_valid) ? ~last_q : m1_valid;
               g_d       = grant;
               s_addr_d  = grant ? m1_addr  : m0_addr;
               s_wdata_d = grant ? m1_wdata : m0_wdata;
               s_wstrb_d = grant ? m1_wstrb : m0_wstrb;
               s_valid_d = 1'b1;
               cnt_d     = '0;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (s_ready || (cnt_q == CNT_LAST)) begin
               // s_ready takes priority over an expiring timeout
               rsp_data      = s_ready ? s_rdata : {DW{1'b1}};
               timeout_err_d = ~s_ready;
               if (g_q) begin
                  m1_rdata_d = rsp_data;
                  m1_ready_d = 1'b1;
               end else begin
                  m0_rdata_d = rsp_data;
                  m0_ready_d = 1'b1;
               end
               s_valid_d = 1'b0;
               s_addr_d  = '0;
               s_wdata_d = '0;
               s_wstrb_d = '0;
               last_d    = g_q;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign s_valid     = s_valid_q;
   assign s_addr      = s_addr_q;
   assign s_wdata     = s_wdata_q;
   assign s_wstrb     = s_wstrb_q;
   assign m0_ready    = m0_ready_q;
   assign m1_ready    = m1_ready_q;
   assign m0_rdata    = m0_rdata_q;
   assign m1_rdata    = m1_rdata_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed master requests, a delay-programmable
// slave, and monitors comparing master responses and slave-side requests.
module tb_bus_arbiter;

   logic        clk;
   logic        reset;
   logic        m0_valid, m1_valid;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid;
   logic [31:0] s_addr, s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_ready;
   logic [31:0] s_rdata;
   logic        timeout_err;

   typedef struct packed {
      logic        m;
      logic [31:0] rdata;
      logic        to;
   } rsp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] len;
   } req_t;

   rsp_t rsp_q[$];
   req_t req_q[$];

   int          tests = 0;
   int          fails = 0;
   int          sl_delay = 0;
   logic [31:0] sl_key = '0;

   bus_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive a master request and record what the bench expects back
   task automatic issue(input int m, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_to,
                        input int len, input bit expect_rsp);
      rsp_t r;
      req_t q;
      if (m == 0) begin
         m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = st;
      end else begin
         m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = st;
      end
      q.addr = a; q.wdata = wd; q.wstrb = st; q.len = 32'(len);
      req_q.push_back(q);
      if (expect_rsp) begin
         r.m = (m != 0); r.rdata = exp_rd; r.to = exp_to;
         rsp_q.push_back(r);
      end
   endtask

   task automatic wait_ready(input int m, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if ((m == 0 && m0_ready === 1'b1) || (m == 1 && m1_ready === 1'b1)) seen = 1'b1;
      end
      if (m == 0) m0_valid = 1'b0;
      else        m1_valid = 1'b0;
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL wait_ready_m%0d: actual=no ready required=ready within %0d cycles", m, budget);
      end
   endtask

   // Slave model: ready after sl_delay cycles of s_valid (never if negative)
   initial begin : slave
      int s_cyc;
      s_cyc   = 0;
      s_ready = 1'b0;
      s_rdata = '0;
      forever begin
         @(negedge clk);
         if (s_valid === 1'b1) begin
            s_ready = (sl_delay >= 0 && s_cyc == sl_delay) ? 1'b1 : 1'b0;
            s_cyc++;
         end else begin
            s_ready = 1'b0;
            s_cyc   = 0;
         end
         s_rdata = s_addr ^ sl_key;
      end
   end

   // Master-response monitor
   initial begin : rsp_mon
      rsp_t e;
      forever begin
         @(negedge clk);
         if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
            check("ready_exclusive", 32'(m0_ready & m1_ready), 32'd0);
            if (rsp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ready: actual=m0:%b m1:%b required=no ready", m0_ready, m1_ready);
            end else begin
               e = rsp_q.pop_front();
               check("rsp_master", 32'(m1_ready), 32'(e.m));
               check("rsp_rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
               check("rsp_timeout_err", 32'(timeout_err), 32'(e.to));
            end
         end else if (timeout_err === 1'b1) begin
            tests++;
            fails++;
            $display("FAIL stray_timeout_err: actual=1 required=0 without ready");
         end
      end
   end

   // Slave-request monitor: fields captured on s_valid rise, compared on its fall
   initial begin : req_mon
      logic        prev;
      logic        stable;
      int          len;
      logic [31:0] c_addr, c_wdata;
      logic [3:0]  c_wstrb;
      req_t        e;
      prev = 1'b0; stable = 1'b1; len = 0;
      c_addr = '0; c_wdata = '0; c_wstrb = '0;
      forever begin
         @(negedge clk);
         if (s_valid === 1'b1) begin
            if (!prev) begin
               c_addr = s_addr; c_wdata = s_wdata; c_wstrb = s_wstrb;
               stable = 1'b1; len = 1;
            end else begin
               len++;
               if (s_addr !== c_addr || s_wdata !== c_wdata || s_wstrb !== c_wstrb) stable = 1'b0;
            end
            prev = 1'b1;
         end else begin
            if (prev) begin
               if (req_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_s_valid: actual addr=%h required=no request", c_addr);
               end else begin
                  e = req_q.pop_front();
                  check("req_addr", c_addr, e.addr);
                  check("req_wdata", c_wdata, e.wdata);
                  check("req_wstrb", 32'(c_wstrb), 32'(e.wstrb));
                  check("req_stable", 32'(stable), 32'd1);
                  check("req_s_valid_len", 32'(len), e.len);
               end
            end
            prev = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "bench hung");
   end

   initial begin : main
      reset = 1'b1;
      m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_s_valid", 32'(s_valid), 32'd0);
      check("rst_s_addr", s_addr, 32'd0);
      check("rst_s_wdata", s_wdata, 32'd0);
      check("rst_m0_ready", 32'(m0_ready), 32'd0);
      check("rst_m1_ready", 32'(m1_ready), 32'd0);
      check("rst_m0_rdata", m0_rdata, 32'd0);
      check("rst_m1_rdata", m1_rdata, 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);

      // Tie after reset: m0 first, m1 right after the RESP->IDLE cycle
      sl_delay = 0; sl_key = '0;
      issue(0, 32'h10, 32'h0, 4'h0, 32'h10, 1'b0, 1, 1'b1);
      issue(1, 32'h20, 32'h0, 4'h0, 32'h20, 1'b0, 1, 1'b1);
      @(negedge clk);
      check("tie1_first_addr", s_addr, 32'h10);
      wait_ready(0, 10);
      @(negedge clk);
      check("tie1_gap_idle", 32'(s_valid), 32'd0);
      @(negedge clk);
      check("tie1_second_valid", 32'(s_valid), 32'd1);
      check("tie1_second_addr", s_addr, 32'h20);
      wait_ready(1, 10);

      // Second tie: m1 was served last, so m0 wins again
      @(negedge clk);
      issue(0, 32'h30, 32'h0, 4'h0, 32'h30, 1'b0, 1, 1'b1);
      issue(1, 32'h40, 32'h0, 4'h0, 32'h40, 1'b0, 1, 1'b1);
      wait_ready(0, 10);
      wait_ready(1, 10);

      // Single read with a two-cycle slave delay
      @(negedge clk);
      sl_delay = 2; sl_key = 32'h1234_5778;
      issue(0, 32'h100, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3, 1'b1);
      @(negedge clk);
      check("read_latency_s_valid", 32'(s_valid), 32'd1);
      check("read_s_addr", s_addr, 32'h100);
      wait_ready(0, 10);
      check("read_m0_rdata", m0_rdata, 32'h1234_5678);

      // Tie with m0 served last: m1 goes first
      @(negedge clk);
      sl_delay = 0; sl_key = '0;
      issue(1, 32'h60, 32'h0, 4'h0, 32'h60, 1'b0, 1, 1'b1);
      issue(0, 32'h50, 32'h0, 4'h0, 32'h50, 1'b0, 1, 1'b1);
      wait_ready(1, 10);
      wait_ready(0, 10);

      // Write from m1
      @(negedge clk);
      sl_delay = 2;
      issue(1, 32'hFFFF_0040, 32'hA5, 4'b0001, 32'hFFFF_0040, 1'b0, 3, 1'b1);
      @(negedge clk);
      check("write_s_wstrb", 32'(s_wstrb), 32'h1);
      check("write_s_wdata", s_wdata, 32'hA5);
      wait_ready(1, 10);

      // Timeout: slave never ready
      @(negedge clk);
      sl_delay = -1;
      issue(0, 32'h200, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b1, 4, 1'b1);
      wait_ready(0, 10);
      check("timeout_err_high", 32'(timeout_err), 32'd1);
      check("timeout_m0_rdata", m0_rdata, 32'hFFFF_FFFF);
      @(negedge clk);
      check("timeout_err_one_cycle", 32'(timeout_err), 32'd0);

      // Boundary: s_ready arrives on the timeout cycle
      sl_delay = 3;
      issue(1, 32'h300, 32'h0, 4'h0, 32'h300, 1'b0, 4, 1'b1);
      wait_ready(1, 10);
      check("boundary_m1_rdata", m1_rdata, 32'h300);
      check("rdata_hold_m0", m0_rdata, 32'hFFFF_FFFF);

      // Reset during the second REQ cycle abandons the transaction
      @(negedge clk);
      sl_delay = -1;
      issue(0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b0, 2, 1'b0);
      @(negedge clk);
      check("midrst_req1_valid", 32'(s_valid), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      m0_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_s_valid", 32'(s_valid), 32'd0);
      check("midrst_s_addr", s_addr, 32'd0);
      check("midrst_m0_ready", 32'(m0_ready), 32'd0);
      check("midrst_timeout_err", 32'(timeout_err), 32'd0);
      check("midrst_m0_rdata", m0_rdata, 32'd0);
      repeat (6) @(negedge clk);
      sl_delay = 1;
      issue(1, 32'h500, 32'h77, 4'hF, 32'h500, 1'b0, 2, 1'b1);
      wait_ready(1, 10);
      check("post_rst_m1_rdata", m1_rdata, 32'h500);

      repeat (4) @(negedge clk);
      check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
      check("req_queue_empty", 32'(req_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
